// File: rtl/periph_timer_bank.sv
`default_nettype none
// ============================================================================
// periph_timer_bank : N_CH memory-mapped 32-bit timers sharing one prescaler
// Rev 1.0 - initial release
// ============================================================================
module periph_timer_bank #(
   parameter int N_CH     = 4,
   parameter int ABITS    = 6,
   parameter int PRESCALE = 118
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [ABITS-1:0] A,
   input  logic [31:0]      WD,
   input  logic             WE,
   output logic [31:0]      RD,
   output logic             irq
);

   localparam int CW = ABITS - 4;
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

   localparam logic [1:0] REG_CTRL  = 2'd0;
   localparam logic [1:0] REG_COUNT = 2'd1;
   localparam logic [1:0] REG_CMP   = 2'd2;
   localparam logic [1:0] REG_STAT  = 2'd3;

   logic [PW-1:0]      presc;
   logic               tick;
   logic [CW-1:0]      ch_idx;
   logic [1:0]         reg_sel;
   logic [N_CH*32-1:0] rd_flat;
   logic [N_CH-1:0]    irq_src;
   logic               unused_abits;

   assign ch_idx       = A[ABITS-1:4];
   assign reg_sel      = A[3:2];
   assign unused_abits = ^A[1:0];
   assign tick         = (presc == PRE_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       presc <= '0;
      else if (tick) presc <= '0;
      else           presc <= presc + 1'b1;
   end

   generate
      for (genvar c = 0; c < N_CH; c++) begin : g_ch
         logic [3:0]  ctrl;  // {IE, ONESHOT, RELOAD, EN}
         logic [31:0] count;
         logic [31:0] cmp;
         logic [31:0] nxt;
         logic        pend;
         logic        sel;
         logic        hit;

         assign sel = WE && (ch_idx == CW'(c));
         assign nxt = count + 32'd1;
         // In reload mode CMP=0 could only be reached by the free wrap, which must not match
         assign hit = tick && ctrl[0] && (nxt == cmp) && !(ctrl[1] && (cmp == 32'd0));

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               ctrl  <= 4'd0;
               count <= 32'd0;
               cmp   <= 32'hFFFF_FFFF;
               pend  <= 1'b0;
            end else begin
               if (sel && (reg_sel == REG_CTRL))
                  ctrl <= WD[3:0];
               else if (hit && ctrl[2])
                  ctrl[0] <= 1'b0;

               if (sel && (reg_sel == REG_COUNT))
                  count <= WD;
               else if (tick && ctrl[0])
                  count <= (hit && ctrl[1]) ? 32'd0 : nxt;

               if (sel && (reg_sel == REG_CMP))
                  cmp <= WD;

               if (hit)
                  pend <= 1'b1;
               else if (sel && (reg_sel == REG_STAT) && WD[0])
                  pend <= 1'b0;
            end
         end

         assign irq_src[c] = pend & ctrl[3];
         assign rd_flat[c*32 +: 32] = (reg_sel == REG_CTRL)  ? {28'd0, ctrl} :
                                      (reg_sel == REG_COUNT) ? count :
                                      (reg_sel == REG_CMP)   ? cmp   :
                                                               {31'd0, pend};
      end
   endgenerate

   // Unpopulated channel slots fall through to zero
   always_comb begin
      RD = 32'd0;
      for (int c = 0; c < N_CH; c++) begin
         if (ch_idx == CW'(c)) RD = rd_flat[c*32 +: 32];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) irq <= 1'b0;
      else     irq <= |irq_src;
   end

endmodule
`default_nettype wire

// File: tb/tb_periph_timer_bank.sv
`default_nettype none
// ============================================================================
// tb_periph_timer_bank : directed bench with a cycle-level reference model
// Rev 1.0 - initial release
// ============================================================================
module tb_periph_timer_bank;

   localparam int N   = 4;
   localparam int PRE = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  A;
   logic [31:0] WD;
   logic        WE;
   logic [31:0] RD;
   logic        irq;

   logic [6:0]  A2;
   logic [31:0] WD2;
   logic        WE2;
   logic [31:0] RD2;
   logic        irq2;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   logic chk_en = 1'b0;

   periph_timer_bank #(.N_CH(N), .ABITS(6), .PRESCALE(PRE)) dut (
      .clk(clk), .rst(rst), .A(A), .WD(WD), .WE(WE), .RD(RD), .irq(irq)
   );

   periph_timer_bank #(.N_CH(N), .ABITS(7), .PRESCALE(PRE)) dut2 (
      .clk(clk), .rst(rst), .A(A2), .WD(WD2), .WE(WE2), .RD(RD2), .irq(irq2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   logic [3:0]  m_ctrl  [N];
   logic [31:0] m_count [N];
   logic [31:0] m_cmp   [N];
   logic        m_pend  [N];
   int          m_pre;
   logic        m_irq;
   logic [31:0] m_nxt;
   logic        m_hit, m_tk, m_any;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pre = 0;
         m_irq = 1'b0;
         for (int c = 0; c < N; c++) begin
            m_ctrl[c] = 4'd0; m_count[c] = 32'd0; m_cmp[c] = 32'hFFFF_FFFF; m_pend[c] = 1'b0;
         end
      end else begin
         m_tk  = (m_pre == PRE - 1);
         m_pre = (m_pre + 1) % PRE;
         m_any = 1'b0;
         for (int c = 0; c < N; c++) m_any = m_any | (m_pend[c] & m_ctrl[c][3]);
         m_irq = m_any;
         for (int c = 0; c < N; c++) begin
            m_hit = 1'b0;
            if (m_tk && m_ctrl[c][0]) begin
               m_nxt = m_count[c] + 32'd1;
               m_hit = (m_nxt == m_cmp[c]) && !(m_ctrl[c][1] && m_cmp[c] == 32'd0);
               m_count[c] = (m_hit && m_ctrl[c][1]) ? 32'd0 : m_nxt;
               if (m_hit) begin
                  m_pend[c] = 1'b1;
                  if (m_ctrl[c][2]) m_ctrl[c][0] = 1'b0;
               end
            end
            if (WE && int'(A[5:4]) == c) begin
               case (A[3:2])
                  2'd0: m_ctrl[c] = WD[3:0];
                  2'd1: m_count[c] = WD;
                  2'd2: m_cmp[c] = WD;
                  default: if (WD[0] && !m_hit) m_pend[c] = 1'b0;
               endcase
            end
         end
      end
   end

   function automatic logic [31:0] m_read(input logic [5:0] a);
      int ch = int'(a[5:4]);
      if (ch >= N) return 32'd0;
      case (a[3:2])
         2'd0:    return {28'd0, m_ctrl[ch]};
         2'd1:    return m_count[ch];
         2'd2:    return m_cmp[ch];
         default: return {31'd0, m_pend[ch]};
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_rd", RD, m_read(A));
         chk("model_irq", {31'd0, irq}, {31'd0, m_irq});
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wr(input logic [5:0] a, input logic [31:0] d);
      @(posedge clk); #1; A = a; WD = d; WE = 1'b1;
      @(posedge clk); #1; WE = 1'b0;
   endtask

   task automatic rd_chk(input logic [5:0] a, input logic [31:0] exp, input string name);
      A = a; #1;
      chk(name, RD, exp);
   endtask

   task automatic wait_stat(input logic [5:0] a, input string name, output int t);
      int  n;
      bit  got;
      n = 0; got = 1'b0; t = -1;
      A = a;
      while (!got && n < 200) begin
         @(posedge clk); #2;
         n++;
         if (RD[0]) begin got = 1'b1; t = cyc; end
      end
      if (!got) begin
         n_checks++; n_fail++;
         $display("FAIL %s: PEND timeout, got 0 required 1", name);
      end
   endtask

   logic [31:0] wrap_seq  [4];
   logic [31:0] wrap_pend [4];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   initial begin
      int t0, t1, idx, n;
      logic [31:0] prev;
      A = 6'd0; WD = 32'd0; WE = 1'b0; rst = 1'b0;
      A2 = 7'd0; WD2 = 32'd0; WE2 = 1'b0;
      wrap_seq[0]  = 32'hFFFF_FFFF; wrap_seq[1]  = 32'd0; wrap_seq[2]  = 32'd1; wrap_seq[3]  = 32'd2;
      wrap_pend[0] = 32'd0;         wrap_pend[1] = 32'd0; wrap_pend[2] = 32'd1; wrap_pend[3] = 32'd1;

      #2 rst = 1'b1;
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rd_chk(6'h00, 32'd0, "rst_ctrl0");
      rd_chk(6'h08, 32'hFFFF_FFFF, "rst_cmp0");
      chk("rst_irq", {31'd0, irq}, 32'd0);
      @(posedge clk); #1 rst = 1'b0;

      // 1. reset asserted while channel 0 is counting
      wr(6'h00, 32'h1);
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      rd_chk(6'h04, 32'd0, "rst_mid_count0");
      rd_chk(6'h00, 32'd0, "rst_mid_ctrl0");
      chk("rst_mid_irq", {31'd0, irq}, 32'd0);
      repeat (3) begin
         @(posedge clk); #2;
         rd_chk(6'h04, 32'd0, "rst_frozen_count0");
      end
      @(posedge clk); #1 rst = 1'b0;

      // 2. periodic reload on channel 0
      wr(6'h08, 32'd5);
      wr(6'h00, 32'hB);
      wait_stat(6'h0C, "periodic_pend0", t0);
      rd_chk(6'h04, 32'd0, "periodic_count_reloaded");
      chk("irq_not_yet", {31'd0, irq}, 32'd0);
      @(posedge clk); #2;
      chk("irq_after_pend", {31'd0, irq}, 32'd1);
      wr(6'h0C, 32'h1);
      wait_stat(6'h0C, "periodic_pend0_again", t1);
      chk("period_clks", t1 - t0, 32'd20);

      // 5. collisions: W1C on the match edge, COUNT write on a tick edge
      repeat (18) @(posedge clk);
      wr(6'h0C, 32'h1);
      #1;
      rd_chk(6'h0C, 32'd1, "w1c_vs_match");
      repeat (2) @(posedge clk);
      wr(6'h04, 32'h100);
      #1;
      rd_chk(6'h04, 32'h100, "count_write_vs_tick");
      wr(6'h00, 32'h0);
      wr(6'h0C, 32'h1);

      // 3. one-shot on channel 1
      wr(6'h18, 32'd3);
      wr(6'h10, 32'h5);
      wait_stat(6'h1C, "oneshot_pend1", t0);
      rd_chk(6'h10, 32'h4, "oneshot_ctrl1");
      rd_chk(6'h14, 32'd3, "oneshot_count1");
      chk("oneshot_irq", {31'd0, irq}, 32'd0);
      repeat (12) @(posedge clk);
      #2;
      rd_chk(6'h14, 32'd3, "oneshot_hold1");

      // 4. wrap on channel 2 without reload
      wr(6'h24, 32'hFFFF_FFFE);
      wr(6'h28, 32'd1);
      wr(6'h20, 32'h1);
      idx = 0; n = 0; prev = 32'hFFFF_FFFE;
      A = 6'h24;
      while (idx < 4 && n < 60) begin
         @(posedge clk); #2;
         n++;
         if (RD !== prev) begin
            chk("wrap_count2", RD, wrap_seq[idx]);
            prev = RD;
            A = 6'h2C; #1;
            chk("wrap_pend2", {31'd0, RD[0]}, wrap_pend[idx]);
            A = 6'h24;
            idx++;
         end
      end
      if (idx < 4) begin
         n_checks++; n_fail++;
         $display("FAIL wrap_timeout: got %0d steps required 4", idx);
      end
      wr(6'h20, 32'h0);

      // 6. decode of channel 3 and unpopulated slots
      wr(6'h30, 32'h8);
      wr(6'h38, 32'h1234);
      rd_chk(6'h30, 32'h8, "decode_ctrl3");
      rd_chk(6'h38, 32'h1234, "decode_cmp3");
      @(posedge clk); #1;
      rd_chk(6'h08, 32'd5, "decode_cmp0_kept");
      rd_chk(6'h18, 32'd3, "decode_cmp1_kept");
      rd_chk(6'h28, 32'd1, "decode_cmp2_kept");

      @(posedge clk); #1; A2 = 7'h40; WD2 = 32'hF; WE2 = 1'b1;
      @(posedge clk); #1; A2 = 7'h48; WD2 = 32'h5;
      @(posedge clk); #1; A2 = 7'h08; WD2 = 32'h7;
      @(posedge clk); #1; WE2 = 1'b0;
      A2 = 7'h40; #1; chk("oob_ctrl4", RD2, 32'd0);
      A2 = 7'h48; #1; chk("oob_cmp4", RD2, 32'd0);
      A2 = 7'h00; #1; chk("oob_ctrl0_kept", RD2, 32'd0);
      @(posedge clk); #1;
      A2 = 7'h08; #1; chk("inb_cmp0_written", RD2, 32'h7);
      chk("oob_irq", {31'd0, irq2}, 32'd0);

      // CMP=0 in reload mode: counter wraps freely, never pends
      wr(6'h34, 32'hFFFF_FFFF);
      wr(6'h38, 32'd0);
      wr(6'h30, 32'h3);
      repeat (12) @(posedge clk);
      #2;
      rd_chk(6'h3C, 32'd0, "cmp0_reload_nopend");
      A = 6'h34; #1;
      chk("cmp0_reload_wrapped", {31'd0, (RD <= 32'd3)}, 32'd1);
      wr(6'h30, 32'h0);
      repeat (4) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
